// File: rtl/id_exe_reg.sv
// id_exe_reg: pipeline register between Instruction Decode and Execute.
//
// Captures the decoded control bits and operands on every rising edge.
// On freeze it holds everything. On flush it inserts a bubble: all fields
// are cleared to zero and the bubble counter increments.
// Edge priority: freeze > flush > load.
//
// Ports
//   clk, rst            core clock; asynchronous active-low reset
//   freeze, flush       hold / bubble-insert controls
//   *_in                decoded instruction fields from ID
//   *_out               registered copies of every *_in (1-cycle latency)
//   select_out          registered (mem_r_en_in | mem_w_en_in), picks the
//                       load/store offset form in the operand generator
//   bubble_cnt          saturating count of bubbles inserted by flush
module id_exe_reg #(
  parameter int unsigned WORD = 32,
  parameter int unsigned REGA = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            flush,

  input  logic [WORD-1:0] pc_in,
  input  logic            wb_en_in,
  input  logic            mem_r_en_in,
  input  logic            mem_w_en_in,
  input  logic            b_in,
  input  logic            s_in,
  input  logic [3:0]      exe_cmd_in,
  input  logic            imm_in,
  input  logic [11:0]     shift_operand_in,
  input  logic [23:0]     signed_imm_24_in,
  input  logic [WORD-1:0] val_rn_in,
  input  logic [WORD-1:0] val_rm_in,
  input  logic [REGA-1:0] dest_in,
  input  logic [REGA-1:0] src1_in,
  input  logic [REGA-1:0] src2_in,
  input  logic [3:0]      status_in,
  input  logic            valid_in,

  output logic [WORD-1:0] pc_out,
  output logic            wb_en_out,
  output logic            mem_r_en_out,
  output logic            mem_w_en_out,
  output logic            b_out,
  output logic            s_out,
  output logic [3:0]      exe_cmd_out,
  output logic            imm_out,
  output logic [11:0]     shift_operand_out,
  output logic [23:0]     signed_imm_24_out,
  output logic [WORD-1:0] val_rn_out,
  output logic [WORD-1:0] val_rm_out,
  output logic [REGA-1:0] dest_out,
  output logic [REGA-1:0] src1_out,
  output logic [REGA-1:0] src2_out,
  output logic [3:0]      status_out,
  output logic            valid_out,
  output logic            select_out,
  output logic [15:0]     bubble_cnt
);

  localparam logic [15:0] CntMax = 16'hFFFF;

  // Payload registers. Reset and flush both produce the all-zero bubble,
  // which is architecturally inert (no write-back, memory access, branch
  // or status update).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out            <= '0;
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      exe_cmd_out       <= 4'b0000;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm_24_out <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      status_out        <= '0;
      valid_out         <= 1'b0;
      select_out        <= 1'b0;
    end else if (freeze) begin
      // Hold everything; a concurrent flush is dropped, not remembered.
    end else if (flush) begin
      pc_out            <= '0;
      wb_en_out         <= 1'b0;
      mem_r_en_out      <= 1'b0;
      mem_w_en_out      <= 1'b0;
      b_out             <= 1'b0;
      s_out             <= 1'b0;
      exe_cmd_out       <= 4'b0000;
      imm_out           <= 1'b0;
      shift_operand_out <= '0;
      signed_imm_24_out <= '0;
      val_rn_out        <= '0;
      val_rm_out        <= '0;
      dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      status_out        <= '0;
      valid_out         <= 1'b0;
      select_out        <= 1'b0;
    end else begin
      // Invalid slots load as given; the decoder already zeroes their controls.
      pc_out            <= pc_in;
      wb_en_out         <= wb_en_in;
      mem_r_en_out      <= mem_r_en_in;
      mem_w_en_out      <= mem_w_en_in;
      b_out             <= b_in;
      s_out             <= s_in;
      exe_cmd_out       <= exe_cmd_in;
      imm_out           <= imm_in;
      shift_operand_out <= shift_operand_in;
      signed_imm_24_out <= signed_imm_24_in;
      val_rn_out        <= val_rn_in;
      val_rm_out        <= val_rm_in;
      dest_out          <= dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      status_out        <= status_in;
      valid_out         <= valid_in;
      select_out        <= mem_r_en_in | mem_w_en_in;
    end
  end

  // Bubble counter: counts only flushes that take effect, saturates at max.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (!freeze && flush && (bubble_cnt != CntMax)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule
